// File: rtl/imem_responder.sv
// Memory-side responder for the split request/response instruction fetch bus.
// Requests pass a fixed-latency pipeline, read a word-wide memory and queue responses in program order.
module imem_responder #(
    parameter logic [31:0] C_BASE_ADDR    = 32'h0,
    parameter int          C_MEM_DEPTH_X  = 10,
    parameter int          C_FIFO_DEPTH_X = 2,
    parameter int          C_LATENCY      = 1,
    parameter logic [1:0]  C_MIN_HPL      = 2'b00
) (
    input  logic                     clk_i,
    input  logic                     resetb_i,
    input  logic                     clk_en_i,
    output logic                     reqready_o,
    input  logic                     reqvalid_i,
    input  logic [1:0]               reqhpl_i,
    input  logic [31:0]              reqaddr_i,
    input  logic                     rspready_i,
    output logic                     rspvalid_o,
    output logic                     rsprerr_o,
    output logic [31:0]              rspdata_o,
    input  logic                     ldwr_i,
    input  logic [C_MEM_DEPTH_X-1:0] ldaddr_i,
    input  logic [31:0]              lddata_i
);

    localparam int AW         = C_MEM_DEPTH_X;
    localparam int FW         = C_FIFO_DEPTH_X;
    localparam int CW         = C_FIFO_DEPTH_X + 1;
    localparam int MEM_DEPTH  = 1 << C_MEM_DEPTH_X;
    localparam int FIFO_DEPTH = 1 << C_FIFO_DEPTH_X;
    localparam logic [CW-1:0] FIFO_FULL = CW'(FIFO_DEPTH);

    // Misaligned, out-of-window or under-privileged requests; borrows avoid constant compares.
    function automatic logic req_error(input logic [31:0] addr, input logic [1:0] hpl);
        logic [32:0] diff_v;
        logic [2:0]  hpl_diff_v;
        diff_v     = {1'b0, addr} - {1'b0, C_BASE_ADDR};
        hpl_diff_v = {1'b0, hpl} - {1'b0, C_MIN_HPL};
        return (addr[1:0] != 2'b00) || diff_v[32] ||
               ((diff_v[31:0] >> (AW + 2)) != 32'd0) || hpl_diff_v[2];
    endfunction

    function automatic logic [AW-1:0] req_index(input logic [31:0] addr);
        return AW'((addr - C_BASE_ADDR) >> 2);
    endfunction

    logic [31:0]   mem_r [MEM_DEPTH];
    logic [CW-1:0] cnt_r;
    logic          full_r;
    logic [CW-1:0] cnt_nxt_s;
    logic          accept_s;
    logic          pop_s;
    logic          req_err_s;
    logic [AW-1:0] req_idx_s;
    logic          push_s;
    logic          push_err_s;
    logic [AW-1:0] push_idx_s;
    logic [31:0]   push_data_s;

    logic [FIFO_DEPTH-1:0] q_vld_r;
    logic [FIFO_DEPTH-1:0] q_err_r;
    logic [31:0]           q_data_r [FIFO_DEPTH];
    logic [CW-1:0]         q_cnt_r;
    logic [FW-1:0]         wr_idx_s;

    assign accept_s   = clk_en_i & reqvalid_i & reqready_o;
    assign pop_s      = clk_en_i & q_vld_r[0] & rspready_i;
    assign req_err_s  = req_error(reqaddr_i, reqhpl_i);
    assign req_idx_s  = req_index(reqaddr_i);
    assign cnt_nxt_s  = cnt_r + {{(CW-1){1'b0}}, accept_s} - {{(CW-1){1'b0}}, pop_s};
    assign reqready_o = resetb_i & ~full_r;

    // Preload port: bench-side writes, active regardless of reset and clock enable.
    always_ff @(posedge clk_i) begin
        if (ldwr_i) begin
            mem_r[ldaddr_i] <= lddata_i;
        end
    end

    generate
        if (C_LATENCY == 1) begin : g_direct
            assign push_s     = accept_s;
            assign push_err_s = req_err_s;
            assign push_idx_s = req_idx_s;
        end else begin : g_pipe
            localparam int STAGES = C_LATENCY - 1;
            logic [STAGES-1:0] stg_vld_r;
            logic [STAGES-1:0] stg_err_r;
            logic [AW-1:0]     stg_idx_r [STAGES];

            // Latency pipeline carrying the decoded request to the memory-read edge.
            always_ff @(posedge clk_i or negedge resetb_i) begin
                if (!resetb_i) begin
                    stg_vld_r <= '0;
                    stg_err_r <= '0;
                    for (int i = 0; i < STAGES; i++) begin
                        stg_idx_r[i] <= '0;
                    end
                end else if (clk_en_i) begin
                    stg_vld_r[0] <= accept_s;
                    stg_err_r[0] <= req_err_s;
                    stg_idx_r[0] <= req_idx_s;
                    for (int i = 1; i < STAGES; i++) begin
                        stg_vld_r[i] <= stg_vld_r[i-1];
                        stg_err_r[i] <= stg_err_r[i-1];
                        stg_idx_r[i] <= stg_idx_r[i-1];
                    end
                end
            end

            assign push_s     = clk_en_i & stg_vld_r[STAGES-1];
            assign push_err_s = stg_err_r[STAGES-1];
            assign push_idx_s = stg_idx_r[STAGES-1];
        end
    endgenerate

    assign push_data_s = push_err_s ? 32'h0 : mem_r[push_idx_s];
    // A simultaneous pop shifts the queue down, so the push lands one slot lower.
    assign wr_idx_s    = FW'(q_cnt_r - {{(CW-1){1'b0}}, pop_s});

    // Outstanding count; ready is registered so rspready_i never reaches reqready_o.
    always_ff @(posedge clk_i or negedge resetb_i) begin
        if (!resetb_i) begin
            cnt_r  <= '0;
            full_r <= 1'b0;
        end else if (clk_en_i) begin
            cnt_r  <= cnt_nxt_s;
            full_r <= (cnt_nxt_s == FIFO_FULL);
        end
    end

    // Response queue, head at entry 0; vacated slots fill with zeros so empty outputs read 0.
    always_ff @(posedge clk_i or negedge resetb_i) begin
        if (!resetb_i) begin
            q_vld_r <= '0;
            q_err_r <= '0;
            q_cnt_r <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                q_data_r[i] <= 32'h0;
            end
        end else if (clk_en_i) begin
            if (pop_s) begin
                for (int i = 0; i < FIFO_DEPTH - 1; i++) begin
                    q_vld_r[i]  <= q_vld_r[i+1];
                    q_err_r[i]  <= q_err_r[i+1];
                    q_data_r[i] <= q_data_r[i+1];
                end
                q_vld_r[FIFO_DEPTH-1]  <= 1'b0;
                q_err_r[FIFO_DEPTH-1]  <= 1'b0;
                q_data_r[FIFO_DEPTH-1] <= 32'h0;
            end
            if (push_s) begin
                q_vld_r[wr_idx_s]  <= 1'b1;
                q_err_r[wr_idx_s]  <= push_err_s;
                q_data_r[wr_idx_s] <= push_data_s;
            end
            q_cnt_r <= q_cnt_r + {{(CW-1){1'b0}}, push_s} - {{(CW-1){1'b0}}, pop_s};
        end
    end

    assign rspvalid_o = q_vld_r[0];
    assign rsprerr_o  = q_err_r[0];
    assign rspdata_o  = q_data_r[0];

endmodule
